// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : UART state encodings and bit-timing helpers shared by TX and RX.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

   typedef logic [2:0] state_t;

   localparam state_t c_ST_IDLE   = 3'd0;
   localparam state_t c_ST_START  = 3'd1;
   localparam state_t c_ST_DATA   = 3'd2;
   localparam state_t c_ST_PARITY = 3'd3;
   localparam state_t c_ST_STOP   = 3'd4;

   // Rounded to the nearest clock so the baud error stays symmetric.
   function automatic int bit_time(input int clk_freq, input int baud_rate);
      return (clk_freq + baud_rate / 2) / baud_rate;
   endfunction

   function automatic int cnt_width(input int bit_t);
      return $clog2(bit_t) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_baud_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_baud_tick
// Brief    : Bit-period counter 0..BIT_TIME-1 with clear; one-cycle end-of-bit tick.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_baud_tick #(
   parameter int BIT_TIME = 10,
   parameter int CNT_W    = 5
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   output logic o_tick
);

   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(BIT_TIME - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_tick;

   assign w_tick = (r_cnt == c_LAST);
   assign o_tick = w_tick;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (w_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : 8N1 UART transmitter; define UART_TX_PARITY_EN for an even parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 80_000_000,
   parameter int BAUD_RATE = 115200
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_ready,
   output logic       o_tx,
   output logic       o_tx_busy,
   output logic       o_tx_done,
   output logic [2:0] o_state_debug
);

   localparam int c_BIT_TIME = bit_time(CLK_FREQ, BAUD_RATE);
   localparam int c_CNT_W    = cnt_width(c_BIT_TIME);

   state_t     r_state;
   state_t     w_next;
   logic       w_idle;
   logic       w_tick;
   logic       w_tx;
   logic       w_stop_end;
   logic [7:0] r_shift;
   logic [2:0] r_bit_idx;
   logic       r_tx;
   logic       r_stop_end;
   logic       r_done;

   assign w_idle = (r_state == c_ST_IDLE);

   // Counter is held at zero while idle, so acceptance starts a fresh bit period.
   uart_tx_baud_tick #(
      .BIT_TIME (c_BIT_TIME),
      .CNT_W    (c_CNT_W)
   ) u_baud_tick (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_clr  (w_idle),
      .o_tick (w_tick)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_ST_IDLE:   if (i_valid) w_next = c_ST_START;
         c_ST_START:  if (w_tick) w_next = c_ST_DATA;
         c_ST_DATA: begin
            if (w_tick && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
               w_next = c_ST_PARITY;
`else
               w_next = c_ST_STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         c_ST_PARITY: if (w_tick) w_next = c_ST_STOP;
`endif
         c_ST_STOP:   if (w_tick) w_next = c_ST_IDLE;
         default:     w_next = c_ST_IDLE;
      endcase
   end

   always_comb begin
      w_tx       = 1'b1;
      w_stop_end = 1'b0;
      case (r_state)
         c_ST_START:  w_tx = 1'b0;
         c_ST_DATA:   w_tx = r_shift[r_bit_idx];
`ifdef UART_TX_PARITY_EN
         c_ST_PARITY: w_tx = ^r_shift;
`endif
         c_ST_STOP:   w_stop_end = w_tick;
         default:     w_tx = 1'b1;
      endcase
   end

   // Done trails the wire's stop bit by one cycle so it lands one full frame after the fall.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_shift    <= '0;
         r_bit_idx  <= '0;
         r_tx       <= 1'b1;
         r_stop_end <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_tx       <= w_tx;
         r_stop_end <= w_stop_end;
         r_done     <= r_stop_end;
         if (w_idle && i_valid) begin
            r_shift <= i_data;
         end
         if ((r_state == c_ST_DATA) && w_tick) begin
            r_bit_idx <= (r_bit_idx == 3'd7) ? 3'd0 : r_bit_idx + 3'd1;
         end
      end
   end

   assign o_ready       = w_idle;
   assign o_tx          = r_tx;
   assign o_tx_busy     = ~w_idle;
   assign o_tx_done     = r_done;
   assign o_state_debug = r_state;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Self-checking bench for uart_tx with a behavioural line receiver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

   localparam int CLK_FREQ = 1_000_000;
   localparam int BAUD     = 100_000;
   localparam int BT       = (CLK_FREQ + BAUD / 2) / BAUD;
`ifdef UART_TX_PARITY_EN
   localparam int NSLOT    = 11;
`else
   localparam int NSLOT    = 10;
`endif
   localparam int FL       = NSLOT * BT;
   localparam int LIMIT    = 4 * FL;

   typedef struct packed {
      logic       rst;
      logic       valid;
      logic [7:0] data;
      logic       tx;
      logic       ready;
      logic       busy;
      logic       done;
      logic [2:0] st;
   } vec_t;

   logic       clk     = 1'b0;
   logic       i_rst   = 1'b0;
   logic       i_valid = 1'b0;
   logic [7:0] i_data  = 8'h00;
   logic       o_ready, o_tx, o_tx_busy, o_tx_done;
   logic [2:0] o_state_debug;

   int n_chk  = 0;
   int n_pass = 0;

   logic       log_tx[$];
   logic       log_done[$];
   logic       log_rdy[$];
   logic       log_busy[$];
   logic [7:0] exp_q[$];
   logic [7:0] dec_q[$];
   logic       par_q[$];
   int         fall_q[$];

   uart_tx #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD)
   ) dut (
      .i_clk         (clk),
      .i_rst         (i_rst),
      .i_data        (i_data),
      .i_valid       (i_valid),
      .o_ready       (o_ready),
      .o_tx          (o_tx),
      .o_tx_busy     (o_tx_busy),
      .o_tx_done     (o_tx_done),
      .o_state_debug (o_state_debug)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      log_tx.push_back(o_tx);
      log_done.push_back(o_tx_done);
      log_rdy.push_back(o_ready);
      log_busy.push_back(o_tx_busy);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
   endtask

   task automatic log_reset();
      @(posedge clk);
      log_tx.delete(); log_done.delete(); log_rdy.delete(); log_busy.delete();
      exp_q.delete();
      @(negedge clk);
   endtask

   // Producer side: hold the byte until the transmitter is ready, then release.
   task automatic send(input logic [7:0] d);
      int n;
      n = 0;
      i_valid = 1'b1;
      i_data  = d;
      while (o_ready !== 1'b1 && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      chk("handshake_wait", {31'd0, n < LIMIT}, 32'd1);
      exp_q.push_back(d);
      @(negedge clk);
      i_valid = 1'b0;
      i_data  = 8'($urandom);
   endtask

   // Behavioural receiver: finds each falling edge and checks every slot holds BT samples.
   task automatic analyze(output int nfr, output int nbad, output int ndbad);
      int         i, f;
      logic [7:0] b;
      logic       lvl, ok, de;
      int         done_at[$];
      dec_q.delete(); fall_q.delete(); par_q.delete();
      nfr = 0; nbad = 0; ndbad = 0;
      i = 1;
      while (i < log_tx.size()) begin
         if (log_tx[i-1] === 1'b1 && log_tx[i] === 1'b0) begin
            f  = i;
            ok = 1'b1;
            b  = 8'h00;
            if (f + FL >= log_tx.size()) begin
               nbad++;
               break;
            end
            for (int s = 0; s < NSLOT; s++) begin
               lvl = log_tx[f + s*BT];
               for (int k = 1; k < BT; k++)
                  if (log_tx[f + s*BT + k] !== lvl) ok = 1'b0;
               if (s == 0 && lvl !== 1'b0) ok = 1'b0;
               if (s >= 1 && s <= 8) b[s-1] = lvl;
               if (s == 9 && NSLOT == 11) par_q.push_back(lvl);
               if (s == NSLOT-1 && lvl !== 1'b1) ok = 1'b0;
            end
            if (NSLOT == 11 && par_q[par_q.size()-1] !== ^b) ok = 1'b0;
            if (log_tx[f + FL] !== 1'b1) ok = 1'b0;
            for (int k = f - 1; k <= f + FL - 2; k++)
               if (log_rdy[k] !== 1'b0 || log_busy[k] !== 1'b1) ok = 1'b0;
            if (!ok) nbad++;
            dec_q.push_back(b);
            fall_q.push_back(f);
            done_at.push_back(f + FL);
            nfr++;
            i = f + FL;
         end else begin
            i++;
         end
      end
      for (int k = 0; k < log_done.size(); k++) begin
         de = 1'b0;
         foreach (done_at[j]) if (done_at[j] == k) de = 1'b1;
         if (log_done[k] !== de) ndbad++;
      end
   endtask

   task automatic check_frames(input string tag);
      int nfr, nbad, ndbad;
      analyze(nfr, nbad, ndbad);
      chk({tag, "_frames"}, nfr, exp_q.size());
      chk({tag, "_malformed"}, nbad, 0);
      chk({tag, "_done_timing"}, ndbad, 0);
      for (int k = 0; k < exp_q.size(); k++)
         chk($sformatf("%s_byte%0d", tag, k),
             (k < dec_q.size()) ? {24'd0, dec_q[k]} : 32'hFFFF_FFFF, {24'd0, exp_q[k]});
   endtask

   initial begin
      vec_t vecs[8];
      int   dn;
      int   gap_ok;

      vecs[0] = '{rst:1'b1, valid:1'b0, data:8'h00, tx:1'b1, ready:1'b1, busy:1'b0, done:1'b0, st:3'd0};
      vecs[1] = '{rst:1'b0, valid:1'b0, data:8'h00, tx:1'b1, ready:1'b1, busy:1'b0, done:1'b0, st:3'd0};
      vecs[2] = '{rst:1'b0, valid:1'b1, data:8'h55, tx:1'b1, ready:1'b0, busy:1'b1, done:1'b0, st:3'd1};
      vecs[3] = '{rst:1'b0, valid:1'b1, data:8'hAA, tx:1'b0, ready:1'b0, busy:1'b1, done:1'b0, st:3'd1};
      vecs[4] = '{rst:1'b0, valid:1'b0, data:8'h00, tx:1'b0, ready:1'b0, busy:1'b1, done:1'b0, st:3'd1};
      vecs[5] = '{rst:1'b1, valid:1'b1, data:8'h33, tx:1'b1, ready:1'b1, busy:1'b0, done:1'b0, st:3'd0};
      vecs[6] = '{rst:1'b0, valid:1'b0, data:8'h00, tx:1'b1, ready:1'b1, busy:1'b0, done:1'b0, st:3'd0};
      vecs[7] = '{rst:1'b0, valid:1'b0, data:8'h00, tx:1'b1, ready:1'b1, busy:1'b0, done:1'b0, st:3'd0};

      for (int k = 0; k < 8; k++) begin
         i_rst   = vecs[k].rst;
         i_valid = vecs[k].valid;
         i_data  = vecs[k].data;
         @(negedge clk);
         chk($sformatf("vec%0d", k),
             {25'd0, o_tx, o_ready, o_tx_busy, o_tx_done, o_state_debug},
             {25'd0, vecs[k].tx, vecs[k].ready, vecs[k].busy, vecs[k].done, vecs[k].st});
      end
      i_rst = 1'b0; i_valid = 1'b0;

      // Single byte
      log_reset();
      repeat (3) @(negedge clk);
      send(8'h55);
      repeat (FL + 20) @(negedge clk);
      check_frames("single55");

      // Back-to-back with valid held high across the boundary
      log_reset();
      repeat (3) @(negedge clk);
      send(8'hA5);
      send(8'h3C);
      repeat (FL + 20) @(negedge clk);
      check_frames("b2b");
      chk("b2b_spacing", (fall_q.size() >= 2) ? fall_q[1] - fall_q[0] : -1, FL + 1);

      // Inputs thrashed while the frame is on the wire
      log_reset();
      repeat (3) @(negedge clk);
      send(8'h96);
      for (int k = 0; k < 8 * BT; k++) begin
         i_valid = 1'($urandom);
         i_data  = 8'($urandom);
         @(negedge clk);
      end
      i_valid = 1'b0;
      repeat (FL) @(negedge clk);
      check_frames("scramble");

      // Reset mid-frame
      log_reset();
      repeat (3) @(negedge clk);
      send(8'hC3);
      repeat (34) @(negedge clk);
      i_rst = 1'b1;
      @(negedge clk);
      chk("rst_tx", {31'd0, o_tx}, 32'd1);
      chk("rst_ready", {31'd0, o_ready}, 32'd1);
      chk("rst_busy", {31'd0, o_tx_busy}, 32'd0);
      i_rst = 1'b0;
      repeat (FL + 20) @(negedge clk);
      dn = 0;
      foreach (log_done[k]) if (log_done[k] === 1'b1) dn++;
      chk("rst_no_done", dn, 0);
      log_reset();
      repeat (3) @(negedge clk);
      send(8'hFF);
      repeat (FL + 20) @(negedge clk);
      check_frames("after_rst");

      // Loopback bytes into the receiver model
      log_reset();
      repeat (3) @(negedge clk);
      send(8'h00);
      repeat (2) @(negedge clk);
      send(8'hFF);
      send(8'h81);
      repeat (FL + 20) @(negedge clk);
      check_frames("loop");

`ifdef UART_TX_PARITY_EN
      log_reset();
      repeat (3) @(negedge clk);
      send(8'h07);
      send(8'h03);
      repeat (FL + 20) @(negedge clk);
      check_frames("parity");
      chk("parity_07", (par_q.size() >= 1) ? {31'd0, par_q[0]} : 32'hFFFF_FFFF, 32'd1);
      chk("parity_03", (par_q.size() >= 2) ? {31'd0, par_q[1]} : 32'hFFFF_FFFF, 32'd0);
      chk("parity_frame_len", (fall_q.size() >= 2) ? fall_q[1] - fall_q[0] - 1 : -1, 110);
`endif

      // Randomised traffic with random idle gaps
      log_reset();
      repeat (3) @(negedge clk);
      for (int r = 0; r < 6; r++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send(8'($urandom));
      end
      repeat (FL + 20) @(negedge clk);
      check_frames("random");
      gap_ok = 1;
      for (int k = 1; k < fall_q.size(); k++)
         if (fall_q[k] - fall_q[k-1] < FL + 1) gap_ok = 0;
      chk("random_min_gap", gap_ok, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter, the transmit-side companion of the team's UART receiver. Frame timing matches the receiver's.
- Accepts one byte per valid/ready handshake from the core or bus bridge.
- Serialises the byte as: start bit, 8 data bits LSB first, stop bit.
- Drives the TX pad line, which idles high.

Parameters:
- CLK_FREQ, 80_000_000, i_clk frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s.
- Derived, not overridable: BIT_TIME = (CLK_FREQ + BAUD_RATE/2) / BAUD_RATE. Counter width = $clog2(BIT_TIME) + 1.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_data  in  8  byte to send; sampled only on handshake.
- i_valid  in  1  producer has a byte.
- o_ready  out  1  transmitter can accept a byte.
- o_tx  out  1  serial line, registered, idle high.
- o_tx_busy  out  1  frame in progress (state != IDLE).
- o_tx_done  out  1  one-cycle pulse at frame completion.
- o_state_debug  out  3  current state encoding.

Behaviour:
- Reset: reset is synchronous, active-high on i_rst; clock is i_clk. Reset values:
  - state=IDLE, counter=0, bit index=0, shift reg=0
  - o_tx=1, o_tx_done=0, o_ready=1 (first cycle after reset release)
- States and encodings: IDLE=0, START=1, DATA=2, PARITY=3 (only with the optional feature), STOP=4.
- o_ready = (state==IDLE). It is combinational from state and does not depend on i_valid.
- Handshake: a byte is accepted on a rising edge where i_valid && o_ready.
  - On that edge: i_data is latched into the shift register, counter is cleared, state goes to START.
  - i_data may change freely after acceptance.
- Latency: o_tx falls on the edge after acceptance, because it is registered from state.
- Bit length: every bit (start, data, parity, stop) holds exactly BIT_TIME cycles. The counter runs 0..BIT_TIME-1 and then wraps to 0.
- START: o_tx=0. When counter==BIT_TIME-1, go to DATA with bit index=0.
- DATA: o_tx = shift_reg[bit_index].
  - When counter==BIT_TIME-1 and bit_index<7: increment bit_index.
  - When counter==BIT_TIME-1 and bit_index==7: go to STOP (or PARITY if enabled).
  - bit_index wraps to 0 when leaving DATA.
- STOP: o_tx=1. When counter==BIT_TIME-1: go to IDLE and pulse o_tx_done for exactly that cycle.
- Frame length: 10*BIT_TIME cycles from o_tx falling to o_tx_done. The next start bit can begin no earlier than 1 cycle after STOP ends, so there is at least 1 idle-high cycle between back-to-back frames.
- Busy and debug: o_tx_busy is high from the cycle after acceptance until IDLE is re-entered. o_state_debug mirrors the state register.
- i_valid outside IDLE is ignored. No byte is lost, because o_ready is low during a frame.
- Reset mid-frame: on the next edge o_tx=1 and state=IDLE. The frame is truncated and no o_tx_done pulse is produced.
- Illegal state encoding: go to IDLE with o_tx=1.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - o_tx = ^shift_reg (even parity) for BIT_TIME cycles.
  - Frame length becomes 11*BIT_TIME cycles.
- Undefined:
  - PARITY state and its logic are absent.
  - DATA goes directly to STOP.
  - Encoding 3 is treated as illegal and recovers to IDLE.

Decomposition:
- Shared package uart_pkg:
  - State encodings, shared with the receiver's debug decoding.
  - bit_time(CLK_FREQ, BAUD_RATE) function.
  - Counter-width function.
- One natural sub-module, uart_tx_baud_tick:
  - Counts 0..BIT_TIME-1 with a clear input.
  - Outputs a one-cycle end-of-bit tick.
  - The FSM is clocked by that tick.

Test Plan (all scenarios use CLK_FREQ=1_000_000, BAUD_RATE=100_000, so BIT_TIME=10):
- Single byte 0x55 → o_tx low 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, then high 10 cycles. o_tx_done pulses at cycle 100 after the fall, exactly once.
- Back-to-back 0xA5 then 0x3C with i_valid held high → second start bit begins exactly 101 cycles after the first. o_ready is low throughout each frame. Both bytes are decoded correctly.
- i_valid toggled and i_data changed mid-frame → transmitted byte equals the value latched at acceptance. No extra frames are sent.
- i_rst asserted at cycle 35 of a frame → o_tx=1, o_ready=1 and o_tx_busy=0 on the next edge. No o_tx_done pulse. A following byte 0xFF transmits correctly.
- Loopback o_tx to the receiver, sending 0x00, 0xFF, 0x81 → the receiver reports matching data with valid each time.
- UART_TX_PARITY_EN defined, sending 0x07 → parity bit=1 and frame length is 110 cycles. Sending 0x03 → parity bit=0.
